// File: rtl/sha256_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sha256_pkg : shared types and padding helpers for the SHA-256 msg buffer |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
package sha256_pkg;

  typedef enum logic [1:0] {
    S_DATA = 2'd0,
    S_PAD  = 2'd1,
    S_LEN  = 2'd2,
    S_WAIT = 2'd3
  } msg_state_t;

  localparam logic [31:0] PAD_WORD   = 32'h8000_0000;
  localparam int unsigned LEN_HI_IDX = 14;

  // Keep the first nbytes bytes of a big-endian word, then the 0x80 marker, then zeros.
  function automatic logic [31:0] pad_last_word(input logic [31:0] data,
                                                input logic [1:0]  nbytes);
    case (nbytes)
      2'd1:    pad_last_word = {data[31:24], 8'h80, 16'h0000};
      2'd2:    pad_last_word = {data[31:16], 8'h80, 8'h00};
      2'd3:    pad_last_word = {data[31:8], 8'h80};
      default: pad_last_word = data;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_msg_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sha256_msg_writer : word stream -> padded 512-bit blocks in a 16x32 RAM  |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
module sha256_msg_writer
  import sha256_pkg::*;
#(
  parameter int W = 32,
  parameter int L = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W-1:0]         s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  input  logic [1:0]           s_nbytes,
  output logic                 s_ready,
  output logic                 wr_en,
  output logic [$clog2(L)-1:0] wr_addr,
  output logic [W-1:0]         wr_data,
  output logic                 blk_valid,
  output logic                 blk_final,
  input  logic                 blk_ack
);

  localparam int AW = $clog2(L);

  msg_state_t    state_q, resume_q;
  logic [AW-1:0] idx_q, wr_addr_q;
  logic [63:0]   bitlen_q;
  logic [W-1:0]  wr_data_q;
  logic          pad_mark_q, final_q, emit_q;
  logic          s_ready_q, wr_en_q, blk_valid_q, blk_final_q;

  logic [AW-1:0] idx_inc;
  logic          idx_last, accept, part_last;
  logic [63:0]   len_add;

  always_comb begin
    idx_inc   = idx_q + 1'b1;
    idx_last  = (idx_q == AW'(L - 1));
    accept    = s_valid & s_ready_q;
    part_last = s_last & (s_nbytes != 2'd0);
    len_add   = part_last ? {59'd0, s_nbytes, 3'd0} : 64'd32;
  end

  // A block is emitted whenever idx 15 is written; blk_valid follows one cycle
  // later (emit_q) so the core never sees the block before the last word lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_DATA;
      resume_q    <= S_DATA;
      idx_q       <= '0;
      bitlen_q    <= '0;
      pad_mark_q  <= 1'b0;
      final_q     <= 1'b0;
      emit_q      <= 1'b0;
      s_ready_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      blk_valid_q <= 1'b0;
      blk_final_q <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (emit_q) begin
        emit_q      <= 1'b0;
        blk_valid_q <= 1'b1;
        blk_final_q <= final_q;
      end
      case (state_q)
        S_DATA: begin
          s_ready_q <= 1'b1;
          if (accept) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= idx_q;
            wr_data_q <= s_last ? pad_last_word(s_data, s_nbytes) : s_data;
            idx_q     <= idx_inc;
            bitlen_q  <= bitlen_q + len_add;
            if (s_last) pad_mark_q <= part_last;
            if (idx_last) begin
              state_q   <= S_WAIT;
              resume_q  <= s_last ? S_PAD : S_DATA;
              final_q   <= 1'b0;
              emit_q    <= 1'b1;
              s_ready_q <= 1'b0;
            end else if (s_last) begin
              s_ready_q <= 1'b0;
              // A partial last word at idx 13 already carries the marker: length goes next.
              state_q   <= (part_last && idx_inc == AW'(LEN_HI_IDX)) ? S_LEN : S_PAD;
            end
          end
        end
        S_PAD: begin
          wr_en_q    <= 1'b1;
          wr_addr_q  <= idx_q;
          wr_data_q  <= pad_mark_q ? '0 : PAD_WORD;
          pad_mark_q <= 1'b1;
          idx_q      <= idx_inc;
          if (idx_last) begin
            state_q  <= S_WAIT;
            resume_q <= S_PAD;
            final_q  <= 1'b0;
            emit_q   <= 1'b1;
          end else if (idx_inc == AW'(LEN_HI_IDX)) begin
            state_q <= S_LEN;
          end
        end
        S_LEN: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= idx_q;
          wr_data_q <= idx_last ? bitlen_q[31:0] : bitlen_q[63:32];
          idx_q     <= idx_inc;
          if (idx_last) begin
            state_q  <= S_WAIT;
            resume_q <= S_DATA;
            final_q  <= 1'b1;
            emit_q   <= 1'b1;
          end
        end
        S_WAIT: begin
          if (blk_valid_q && blk_ack) begin
            blk_valid_q <= 1'b0;
            blk_final_q <= 1'b0;
            if (final_q) begin
              state_q    <= S_DATA;
              bitlen_q   <= '0;
              pad_mark_q <= 1'b0;
              final_q    <= 1'b0;
              s_ready_q  <= 1'b1;
            end else begin
              state_q   <= resume_q;
              s_ready_q <= (resume_q == S_DATA);
            end
          end
        end
        default: state_q <= S_DATA;
      endcase
    end
  end

  assign s_ready   = s_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign blk_valid = blk_valid_q;
  assign blk_final = blk_final_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sha256_msg_writer : directed bench for the SHA-256 message writer     |
// | Revision             : 1.0                                               |
// +--------------------------------------------------------------------------+
module tb_sha256_msg_writer;

  logic        clk, rst_n;
  logic [31:0] s_data;
  logic        s_valid, s_last;
  logic [1:0]  s_nbytes;
  logic        s_ready, wr_en, blk_valid, blk_final, blk_ack;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;

  int          n_checks, n_fail;
  int          cyc, acc_cyc;
  logic [31:0] mem   [16];
  logic [31:0] exp_w [16];
  logic        bv_prev;

  sha256_msg_writer #(.W(32), .L(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_nbytes(s_nbytes),
    .s_ready(s_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .blk_valid(blk_valid), .blk_final(blk_final), .blk_ack(blk_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // RAM image; wiped when a block is released so missing writes show up.
  always @(negedge clk) begin
    if (bv_prev && !blk_valid) begin
      for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_BEEF;
    end else if (wr_en === 1'b1) begin
      mem[wr_addr] = wr_data;
    end
    bv_prev = blk_valid;
  end

  task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] nb);
    int n = 0;
    @(negedge clk);
    s_data = d; s_valid = 1'b1; s_last = last; s_nbytes = nb;
    while (s_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_timeout: s_ready=%b required 1", s_ready);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    s_valid = 1'b0; s_last = 1'b0; s_nbytes = 2'd0;
  endtask

  task automatic wait_blk(output bit got);
    int n = 0;
    @(negedge clk);
    while (blk_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    got = (blk_valid === 1'b1);
  endtask

  task automatic ack_blk();
    @(negedge clk);
    blk_ack = 1'b1;
    @(negedge clk);
    blk_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({s_ready, wr_en, wr_addr, wr_data, blk_valid, blk_final} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b we=%b a=%h d=%h bv=%b bf=%b required all 0",
               s_ready, wr_en, wr_addr, wr_data, blk_valid, blk_final);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b required 1", s_ready);
    end
  endtask

  task automatic test_abc();
    bit got;
    send_word(32'h6162_6300, 1'b1, 2'd3);
    wait_blk(got);
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h0;
    exp_w[0] = 32'h6162_6380; exp_w[15] = 32'h18;
    n_checks++;
    if (!got || blk_final !== 1'b1) begin
      n_fail++;
      $display("FAIL abc_block: blk_valid=%b blk_final=%b required 1/1", blk_valid, blk_final);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (mem[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL abc_w%0d: got %h required %h", i, mem[i], exp_w[i]);
      end
    end
    ack_blk();
    n_checks++;
    if (blk_valid !== 1'b0 || blk_final !== 1'b0 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abc_release: bv=%b bf=%b rdy=%b required 0/0/1", blk_valid, blk_final, s_ready);
    end
  endtask

  task automatic test_nbytes();
    bit got;
    logic [31:0] one_byte [3];
    one_byte[0] = 32'hAA80_0000; one_byte[1] = 32'hAABB_8000; one_byte[2] = 32'h8;
    // One-byte and two-byte final words in a single-word message.
    for (int k = 1; k <= 2; k++) begin
      send_word(32'hAABB_CCDD, 1'b1, 2'(k));
      wait_blk(got);
      n_checks++;
      if (!got || mem[0] !== one_byte[k-1] || mem[14] !== 32'h0 || mem[15] !== 32'(8 * k)
          || blk_final !== 1'b1) begin
        n_fail++;
        $display("FAIL nbytes%0d: w0=%h w14=%h w15=%h bf=%b required %h/0/%h/1",
                 k, mem[0], mem[14], mem[15], blk_final, one_byte[k-1], 8 * k);
      end
      ack_blk();
    end
    // Partial last word at idx 13: marker sits inside it, length fits in the same block.
    for (int i = 0; i < 13; i++) send_word(32'h1000_0000 + 32'(i), 1'b0, 2'd0);
    send_word(32'h1122_3344, 1'b1, 2'd2);
    wait_blk(got);
    for (int i = 0; i < 13; i++) exp_w[i] = 32'h1000_0000 + 32'(i);
    exp_w[13] = 32'h1122_8000; exp_w[14] = 32'h0; exp_w[15] = 32'h1B0;
    n_checks++;
    if (!got || blk_final !== 1'b1) begin
      n_fail++;
      $display("FAIL w13_partial_block: bv=%b bf=%b required 1/1", blk_valid, blk_final);
    end
    for (int i = 13; i < 16; i++) begin
      n_checks++;
      if (mem[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL w13_partial_w%0d: got %h required %h", i, mem[i], exp_w[i]);
      end
    end
    ack_blk();
  endtask

  task automatic test_13_words();
    bit got;
    for (int i = 0; i < 13; i++) send_word(32'hA000_0000 + 32'(i), i == 12, 2'd0);
    wait_blk(got);
    for (int i = 0; i < 13; i++) exp_w[i] = 32'hA000_0000 + 32'(i);
    exp_w[13] = 32'h8000_0000; exp_w[14] = 32'h0; exp_w[15] = 32'h1A0;
    n_checks++;
    if (!got || blk_final !== 1'b1) begin
      n_fail++;
      $display("FAIL w13_block: bv=%b bf=%b required 1/1", blk_valid, blk_final);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (mem[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL w13_w%0d: got %h required %h", i, mem[i], exp_w[i]);
      end
    end
    ack_blk();
  endtask

  task automatic test_14_words();
    bit got;
    for (int i = 0; i < 14; i++) send_word(32'hB000_0000 + 32'(i), i == 13, 2'd0);
    wait_blk(got);
    for (int i = 0; i < 14; i++) exp_w[i] = 32'hB000_0000 + 32'(i);
    exp_w[14] = 32'h8000_0000; exp_w[15] = 32'h0;
    n_checks++;
    if (!got || blk_final !== 1'b0) begin
      n_fail++;
      $display("FAIL w14_blk0: bv=%b bf=%b required 1/0", blk_valid, blk_final);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (mem[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL w14_blk0_w%0d: got %h required %h", i, mem[i], exp_w[i]);
      end
    end
    ack_blk();
    n_checks++;
    if (s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL w14_pad_resume: s_ready=%b required 0", s_ready);
    end
    wait_blk(got);
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h0;
    exp_w[15] = 32'h1C0;
    n_checks++;
    if (!got || blk_final !== 1'b1) begin
      n_fail++;
      $display("FAIL w14_blk1: bv=%b bf=%b required 1/1", blk_valid, blk_final);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (mem[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL w14_blk1_w%0d: got %h required %h", i, mem[i], exp_w[i]);
      end
    end
    ack_blk();
  endtask

  task automatic test_back_to_back();
    bit got;
    int c0 = 0;
    for (int i = 0; i < 16; i++) begin
      send_word(32'hC000_0000 + 32'(i), i == 15, 2'd0);
      if (i == 0) c0 = acc_cyc;
    end
    wait_blk(got);
    n_checks++;
    if (!got || cyc - c0 !== 16) begin
      n_fail++;
      $display("FAIL b2b_latency: blk_valid after %0d cycles required 16", cyc - c0);
    end
    n_checks++;
    if (blk_final !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_blk0_final: got %b required 0", blk_final);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (mem[i] !== 32'hC000_0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL b2b_blk0_w%0d: got %h required %h", i, mem[i], 32'hC000_0000 + 32'(i));
      end
    end
    ack_blk();
    wait_blk(got);
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h0;
    exp_w[0] = 32'h8000_0000; exp_w[15] = 32'h200;
    n_checks++;
    if (!got || blk_final !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_blk1: bv=%b bf=%b required 1/1", blk_valid, blk_final);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (mem[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL b2b_blk1_w%0d: got %h required %h", i, mem[i], exp_w[i]);
      end
    end
    ack_blk();
  endtask

  task automatic test_ack_hold();
    bit got;
    send_word(32'h6162_6300, 1'b1, 2'd3);
    wait_blk(got);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (!got || s_ready !== 1'b0 || wr_en !== 1'b0 || blk_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL ack_hold_%0d: rdy=%b we=%b bv=%b required 0/0/1", k, s_ready, wr_en, blk_valid);
      end
    end
    ack_blk();
    n_checks++;
    if (s_ready !== 1'b1 || blk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_release: rdy=%b bv=%b required 1/0", s_ready, blk_valid);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) send_word(32'hD000_0000 + 32'(i), 1'b0, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s_ready, wr_en, wr_addr, wr_data, blk_valid, blk_final} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: rdy=%b we=%b a=%h d=%h bv=%b bf=%b required all 0",
               s_ready, wr_en, wr_addr, wr_data, blk_valid, blk_final);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_abc();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; acc_cyc = 0; bv_prev = 1'b0;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0; s_nbytes = 2'd0; blk_ack = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_BEEF;
    test_reset();
    test_abc();
    test_nbytes();
    test_13_words();
    test_14_words();
    test_back_to_back();
    test_ack_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
